// File: rtl/nios_pio_sw_scan_if.sv
// ---------------------------------------------------------------------------
// nios_pio_sw_scan_if
// Avalon-MM slave bundle for the switch scan controller, plus its interrupt.
//   address    [1:0]  word address (0 DATA, 1 MASK, 2 EDGE, 3 CTRL)
//   chipselect        slave select
//   read              read strobe (reads are side-effect free)
//   write             write strobe
//   writedata  [31:0] write data
//   readdata   [31:0] registered read data, latency 1
//   irq               level interrupt, active-high
// ---------------------------------------------------------------------------
interface nios_pio_sw_scan_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    modport master (
        output address, chipselect, read, write, writedata,
        input  readdata, irq
    );

    modport slave (
        input  address, chipselect, read, write, writedata,
        output readdata, irq
    );
endinterface

// File: rtl/nios_pio_sw_scan.sv
// ---------------------------------------------------------------------------
// nios_pio_sw_scan
// Periodic scan, per-bit debounce and edge capture for a bank of slide
// switches, exposed as an Avalon-MM slave with read latency 1.
//   clk      system clock, rising edge
//   reset    synchronous, active-high
//   bus      Avalon-MM slave (address/chipselect/read/write/writedata/
//            readdata) plus irq
//   in_port  raw asynchronous switch levels, WIDTH bits
// Parameters:
//   WIDTH   switch count (1..32)
//   DIV     clocks per sample tick (>= 2)
//   STABLE  consecutive differing ticks needed to accept a change (>= 1)
// ---------------------------------------------------------------------------
module nios_pio_sw_scan #(
    parameter int unsigned WIDTH  = 18,
    parameter int unsigned DIV    = 50000,
    parameter int unsigned STABLE = 4
) (
    input  logic              clk,
    input  logic              reset,
    nios_pio_sw_scan_if.slave bus,
    input  logic [WIDTH-1:0]  in_port
);
    localparam int unsigned   PW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned   CW       = $clog2(STABLE) + 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE - 1);

    logic [WIDTH-1:0] sync_meta_q, sync_meta_d;
    logic [WIDTH-1:0] sync_q, sync_d;
    logic [PW-1:0]    pre_q, pre_d;
    logic [CW-1:0]    cnt_q [WIDTH];
    logic [CW-1:0]    cnt_d [WIDTH];
    logic [WIDTH-1:0] deb_q, deb_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] edge_cap_q, edge_cap_d;
    logic             ctrl_en_q, ctrl_en_d;
    logic             ctrl_any_q, ctrl_any_d;
    logic [31:0]      readdata_q, readdata_d;

    logic             wr;
    logic             tick;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] edge_set;
    logic [WIDTH-1:0] edge_clr;

    // The read strobe carries no meaning here and the upper write bits are
    // don't-care; folding them keeps them visibly consumed.
    logic unused_bus_bits;
    assign unused_bus_bits = ^{bus.read, bus.writedata};

    always_comb begin
        wr = bus.chipselect && bus.write;

        // Synchronizer: two flops per input bit.
        sync_meta_d = in_port;
        sync_d      = sync_meta_q;

        // Prescaler: frozen at 0 while disabled, so re-enabling starts a
        // full DIV period before the next tick.
        tick  = ctrl_en_q && (pre_q == PRE_LAST);
        pre_d = '0;
        if (ctrl_en_q && !tick) begin
            pre_d = pre_q + PW'(1);
        end

        // Debounce: cnt counts consecutive ticks where sync disagrees with
        // deb; any agreeing tick throws the partial count away.
        deb_d = deb_q;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (tick) begin
                if (sync_q[i] == deb_q[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] == CNT_LAST) begin
                    deb_d[i] = sync_q[i];
                    cnt_d[i] = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end

        // Edge capture uses deb_d so EDGE sets on the same edge deb changes.
        // OR-ing the set after the clear lets a coincident set win.
        rise       = deb_d & ~deb_q;
        fall       = ~deb_d & deb_q;
        edge_set   = ctrl_any_q ? (rise | fall) : rise;
        edge_clr   = (wr && bus.address == 2'd2) ? bus.writedata[WIDTH-1:0] : '0;
        edge_cap_d = (edge_cap_q & ~edge_clr) | edge_set;

        mask_d = mask_q;
        if (wr && bus.address == 2'd1) begin
            mask_d = bus.writedata[WIDTH-1:0];
        end

        ctrl_en_d  = ctrl_en_q;
        ctrl_any_d = ctrl_any_q;
        if (wr && bus.address == 2'd3) begin
            ctrl_en_d  = bus.writedata[0];
            ctrl_any_d = bus.writedata[1];
        end

        // Read mux is registered every cycle regardless of chipselect/read.
        readdata_d = '0;
        case (bus.address)
            2'd0:    readdata_d[WIDTH-1:0] = deb_q;
            2'd1:    readdata_d[WIDTH-1:0] = mask_q;
            2'd2:    readdata_d[WIDTH-1:0] = edge_cap_q;
            default: readdata_d[1:0]       = {ctrl_any_q, ctrl_en_q};
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_meta_q <= '0;
            sync_q      <= '0;
            pre_q       <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
            deb_q       <= '0;
            mask_q      <= '0;
            edge_cap_q  <= '0;
            ctrl_en_q   <= 1'b1;
            ctrl_any_q  <= 1'b0;
            readdata_q  <= '0;
        end else begin
            sync_meta_q <= sync_meta_d;
            sync_q      <= sync_d;
            pre_q       <= pre_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            deb_q       <= deb_d;
            mask_q      <= mask_d;
            edge_cap_q  <= edge_cap_d;
            ctrl_en_q   <= ctrl_en_d;
            ctrl_any_q  <= ctrl_any_d;
            readdata_q  <= readdata_d;
        end
    end

    assign bus.readdata = readdata_q;
    assign bus.irq      = |(edge_cap_q & mask_q);

endmodule

// File: tb/tb_nios_pio_sw_scan.sv
// ---------------------------------------------------------------------------
// tb_nios_pio_sw_scan
// Directed scenarios followed by randomized bus/switch traffic, with every
// cycle's readdata and irq compared against a behavioural reference model.
// ---------------------------------------------------------------------------
module tb_nios_pio_sw_scan;
    localparam int W      = 18;
    localparam int DIV    = 4;
    localparam int STABLE = 3;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] in_port;

    nios_pio_sw_scan_if bus_if ();

    nios_pio_sw_scan #(
        .WIDTH  (W),
        .DIV    (DIV),
        .STABLE (STABLE)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus_if),
        .in_port (in_port)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Samples reach the debouncer two clocks after in_port; a tick falls on
    // every DIV-th enabled clock; a bit accepts a new level once STABLE
    // successive ticks all saw that new level.
    logic [W-1:0] m_s1, m_s2, m_deb, m_mask, m_edge;
    logic [1:0]   m_ctrl;
    int unsigned  m_ecount;
    int           m_run [W];
    logic [31:0]  m_rd;
    logic         m_irq;
    logic         m_valid = 1'b0;
    logic         m_tick, m_wr;
    logic [W-1:0] m_nd, m_set, m_clr;
    logic [31:0]  m_rdn;

    always @(posedge clk) begin
        if (reset) begin
            m_s1 = '0; m_s2 = '0; m_deb = '0; m_mask = '0; m_edge = '0;
            m_ctrl = 2'b01; m_ecount = 0; m_rd = '0;
            for (int i = 0; i < W; i++) m_run[i] = 0;
            m_valid = 1'b1;
        end else begin
            case (bus_if.address)
                2'd0:    m_rdn = 32'(m_deb);
                2'd1:    m_rdn = 32'(m_mask);
                2'd2:    m_rdn = 32'(m_edge);
                default: m_rdn = 32'(m_ctrl);
            endcase
            m_tick = m_ctrl[0] && ((m_ecount % DIV) == DIV - 1);
            m_nd = m_deb;
            if (m_tick) begin
                for (int i = 0; i < W; i++) begin
                    if (m_s2[i] == m_deb[i]) m_run[i] = 0;
                    else begin
                        m_run[i] = m_run[i] + 1;
                        if (m_run[i] == STABLE) begin
                            m_nd[i] = m_s2[i];
                            m_run[i] = 0;
                        end
                    end
                end
            end
            m_set = m_ctrl[1] ? (m_nd ^ m_deb) : (m_nd & ~m_deb);
            m_wr  = bus_if.chipselect && bus_if.write;
            m_clr = (m_wr && bus_if.address == 2'd2) ? bus_if.writedata[W-1:0] : '0;
            m_edge = (m_edge & ~m_clr) | m_set;
            m_ecount = m_ctrl[0] ? m_ecount + 1 : 0;
            if (m_wr && bus_if.address == 2'd1) m_mask = bus_if.writedata[W-1:0];
            if (m_wr && bus_if.address == 2'd3) m_ctrl = bus_if.writedata[1:0];
            m_deb = m_nd;
            m_s2  = m_s1;
            m_s1  = in_port;
            m_rd  = m_rdn;
        end
        m_irq = |(m_edge & m_mask);
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("rd_model", bus_if.readdata, m_rd);
            check("irq_model", {31'b0, bus_if.irq}, {31'b0, m_irq});
        end
    end

    // ---------------- bus helpers ----------------
    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        bus_if.address    = a;
        bus_if.writedata  = d;
        bus_if.chipselect = 1'b1;
        bus_if.write      = 1'b1;
        @(negedge clk);
        bus_if.chipselect = 1'b0;
        bus_if.write      = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        bus_if.address    = a;
        bus_if.chipselect = 1'b1;
        bus_if.read       = 1'b1;
        @(negedge clk);
        d = bus_if.readdata;
        bus_if.chipselect = 1'b0;
        bus_if.read       = 1'b0;
    endtask

    task automatic wait_rd_bit(input logic [1:0] a, input int b, input int lim, input string tag);
        bus_if.address = a;
        for (int k = 0; k < lim && bus_if.readdata[b] !== 1'b1; k++) @(negedge clk);
        check(tag, {31'b0, bus_if.readdata[b]}, 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    logic [31:0] d;
    logic [31:0] rst_exp [4];
    logic        hit;
    int          r;

    initial begin
        reset = 1'b1;
        in_port = '0;
        bus_if.address = '0; bus_if.chipselect = 1'b0; bus_if.read = 1'b0;
        bus_if.write = 1'b0; bus_if.writedata = '0;
        rst_exp[0] = 32'h0; rst_exp[1] = 32'h0; rst_exp[2] = 32'h0; rst_exp[3] = 32'h1;

        // Reset defaults
        repeat (3) @(negedge clk);
        reset = 1'b0;
        for (int a = 0; a < 4; a++) begin
            bus_read(2'(a), d);
            check($sformatf("rst_reg%0d", a), d, rst_exp[a]);
        end
        check("rst_irq", {31'b0, bus_if.irq}, 32'd0);

        // Clean rising edge on bit 0
        bus_write(2'd1, 32'h1);
        in_port[0] = 1'b1;
        wait_rd_bit(2'd0, 0, 2 + DIV * STABLE + 6, "rise_data");
        bus_read(2'd2, d);
        check("rise_edge", d, 32'h1);
        check("rise_irq", {31'b0, bus_if.irq}, 32'd1);
        bus_write(2'd2, 32'h1);
        check("clr_irq", {31'b0, bus_if.irq}, 32'd0);
        bus_read(2'd2, d);
        check("clr_edge", d, 32'h0);

        // Glitch rejection on bit 5
        in_port[5] = 1'b1;
        repeat (6) @(negedge clk);
        in_port[5] = 1'b0;
        repeat (30) @(negedge clk);
        bus_read(2'd0, d);
        check("glitch_data", d, 32'h1);
        bus_read(2'd2, d);
        check("glitch_edge", d, 32'h0);

        // Polarity select on bit 17
        in_port[17] = 1'b1;
        wait_rd_bit(2'd2, 17, 2 + DIV * STABLE + 6, "pol_rise");
        bus_write(2'd2, 32'h3FFFF);
        in_port[17] = 1'b0;
        repeat (25) @(negedge clk);
        bus_read(2'd2, d);
        check("pol_any0_edge", d, 32'h0);
        bus_read(2'd0, d);
        check("pol_data", d, 32'h1);
        in_port[17] = 1'b1;
        repeat (25) @(negedge clk);
        bus_write(2'd2, 32'h3FFFF);
        bus_write(2'd3, 32'h3);
        in_port[17] = 1'b0;
        repeat (25) @(negedge clk);
        bus_read(2'd2, d);
        check("pol_any1_edge", d, 32'h20000);
        check("pol_irq", {31'b0, bus_if.irq}, 32'd0);
        bus_write(2'd2, 32'h3FFFF);
        bus_write(2'd3, 32'h1);

        // Set/clear collision on bit 1
        in_port[1] = 1'b1;
        hit = 1'b0;
        for (int k = 0; k < 40 && !hit; k++) begin
            if (m_ctrl[0] && ((m_ecount % DIV) == DIV - 1) && m_run[1] == STABLE - 1 &&
                m_s2[1] && !m_deb[1]) begin
                bus_write(2'd2, 32'h2);
                hit = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        check("coll_hit", {31'b0, hit}, 32'd1);
        bus_read(2'd2, d);
        check("coll_edge", d & 32'h2, 32'h2);
        bus_write(2'd2, 32'h3FFFF);

        // Enable freeze on bit 3
        bus_write(2'd3, 32'h0);
        in_port[3] = 1'b1;
        repeat (100) @(negedge clk);
        bus_read(2'd0, d);
        check("frz_data", d, 32'h3);
        bus_write(2'd3, 32'h1);
        wait_rd_bit(2'd0, 3, 2 + DIV * STABLE + 6, "frz_resume");
        bus_write(2'd2, 32'h3FFFF);

        // Randomized traffic, including occasional mid-debounce resets
        for (int c = 0; c < 4000; c++) begin
            r = int'($urandom_range(0, 99));
            if (r < 6) begin
                int b;
                b = int'($urandom_range(0, W - 1));
                in_port[b] = ~in_port[b];
            end
            r = int'($urandom_range(0, 199));
            if (r < 1) begin
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
            end else if (r < 6) begin
                bus_write(2'd3, {30'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0)});
            end else if (r < 12) begin
                bus_write(2'($urandom_range(0, 2)), $urandom);
            end else begin
                bus_if.address = 2'($urandom_range(0, 3));
                @(negedge clk);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
